// File: rtl/pipe_seq_ctrl_if.sv
// rtl/pipe_seq_ctrl_if.sv - hazard inputs and register-control outputs of the pipeline sequencer
interface pipe_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_mdu_start;
  logic             id_mdu_read;
  logic             ex_memread;
  logic [4:0]       ex_wn;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             memwb_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic             mdu_busy;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_mdu_start, id_mdu_read,
           ex_memread, ex_wn, ex_redirect, mem_req, mem_ack,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, memwb_flush,
           mdu_busy, mem_err, stall_cnt, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_mdu_start, id_mdu_read,
           ex_memread, ex_wn, ex_redirect, mem_req, mem_ack,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, memwb_flush,
           mdu_busy, mem_err, stall_cnt, state
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// rtl/pipe_seq_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipe_seq_ctrl #(
  parameter int MDU_LAT     = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_MEMW = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  localparam logic [4:0] MDU_LAT_V = 5'(MDU_LAT);
  localparam logic [7:0] TO_V      = 8'(MEM_TIMEOUT);

  state_t           st;
  logic [4:0]       mdu_cnt;
  logic [7:0]       to_cnt;
  logic [CNT_W-1:0] stall_q;
  logic             err_q;

  logic freeze, release_ack, load_use, mdu_hazard, mdu_issue;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic ifid_flush, idex_flush, memwb_flush;
  logic [7:0] to_next;

  assign to_next = to_cnt + 8'd1;

  always_comb begin
    freeze      = (st == ST_MEMW) || (st == ST_RUN && bus.mem_req && !bus.mem_ack);
    release_ack = (st == ST_MEMW) && bus.mem_ack;
    load_use    = bus.ex_memread && (bus.ex_wn != 5'd0) &&
                  ((bus.ex_wn == bus.id_rs) || (bus.id_uses_rt && bus.ex_wn == bus.id_rt));
    mdu_hazard  = (bus.id_mdu_read || bus.id_mdu_start) && (mdu_cnt != 5'd0);
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (st == ST_ERR) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      memwb_flush = 1'b1;
    end else if (freeze) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      // the ack cycle lets MEM/WB capture the returned load data
      memwb_flush = !release_ack;
    end else if (bus.ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || mdu_hazard) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
    mdu_issue = bus.id_mdu_start && idex_we && !idex_flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= ST_RUN;
      mdu_cnt <= 5'd0;
      to_cnt  <= 8'd0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (st)
        ST_RUN: begin
          if (bus.mem_req && !bus.mem_ack) begin
            st     <= ST_MEMW;
            to_cnt <= 8'd1;
          end
        end
        ST_MEMW: begin
          if (bus.mem_ack) begin
            st     <= ST_RUN;
            to_cnt <= 8'd0;
          end else if (to_next == TO_V) begin
            st     <= ST_ERR;
            to_cnt <= to_next;
            err_q  <= 1'b1;
          end else begin
            to_cnt <= to_next;
          end
        end
        ST_ERR:  st <= ST_ERR;
        default: st <= ST_RUN;
      endcase
      if (mdu_issue)
        mdu_cnt <= MDU_LAT_V;
      else if (mdu_cnt != 5'd0)
        mdu_cnt <= mdu_cnt - 5'd1;
      if (st != ST_ERR && !pc_we && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.idex_we     = idex_we;
  assign bus.exmem_we    = exmem_we;
  assign bus.memwb_we    = memwb_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.mdu_busy    = (mdu_cnt != 5'd0);
  assign bus.mem_err     = err_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.state       = st;
endmodule
